// File: rtl/alm_acc_pkg.sv
// Shared types and default sizing for the dot-product accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alm_acc_pkg;

    localparam int ACC_WIDTH_DEF = 40;
    localparam int MAX_LEN_DEF   = 256;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/alm_sat_add.sv
// Saturating two's-complement adder: W-bit operands, clamped W-bit sum.
// Latency: combinational.
// Backpressure: none.
module alm_sat_add #(
    parameter int W = 40
) (
    input  logic signed [W-1:0] acc,
    input  logic signed [W-1:0] addend,
    output logic signed [W-1:0] sum,
    output logic                sat_hit
);

    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] wide;

    // One guard bit: the top two bits disagree exactly when the W-bit result overflowed.
    always_comb begin
        wide    = {acc[W-1], acc} + {addend[W-1], addend};
        sat_hit = wide[W] ^ wide[W-1];
        if (!sat_hit) begin
            sum = wide[W-1:0];
        end else if (wide[W]) begin
            sum = MIN_VAL;
        end else begin
            sum = MAX_VAL;
        end
    end

endmodule

// File: rtl/alm_dot_accumulator.sv
// Accumulates signed products into a saturating sum, emitting one result per vector.
// Latency: result valid the cycle after the closing beat (i_last or MAX_LEN reached).
// Backpressure: o_ready low while a result is held; released one cycle after i_ready.
module alm_dot_accumulator
    import alm_acc_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int MAX_LEN   = MAX_LEN_DEF,
    localparam int CW       = $clog2(MAX_LEN + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [31:0]          i_prod,
    input  logic                        i_last,
    input  logic                        i_clear,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [ACC_WIDTH-1:0] o_acc,
    output logic [CW-1:0]               o_count,
    output logic                        o_sat
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    state_t                 state, state_nxt;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt, sum, prod_ext;
    logic [CW-1:0]          count, count_nxt, count_inc;
    logic                   sat, sat_nxt, sat_hit, accept;

    assign prod_ext  = {{(ACC_WIDTH-32){i_prod[31]}}, i_prod};
    assign count_inc = count + 1'b1;
    assign accept    = i_valid && o_ready && !i_clear;

    alm_sat_add #(.W(ACC_WIDTH)) u_sat_add (
        .acc     (acc),
        .addend  (prod_ext),
        .sum     (sum),
        .sat_hit (sat_hit)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            sat   <= sat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        sat_nxt   = sat;
        case (state)
            ACCUM: begin
                if (i_clear) begin
                    acc_nxt   = '0;
                    count_nxt = '0;
                    sat_nxt   = 1'b0;
                end else if (accept) begin
                    acc_nxt   = sum;
                    count_nxt = count_inc;
                    sat_nxt   = sat | sat_hit;
                    if (i_last || count_inc == MAX_CNT) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                // Result fields stay frozen until the consumer takes them.
                if (i_ready) begin
                    state_nxt = ACCUM;
                    acc_nxt   = '0;
                    count_nxt = '0;
                    sat_nxt   = 1'b0;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign o_ready = (state == ACCUM);
    assign o_valid = (state == HOLD);
    assign o_acc   = acc;
    assign o_count = count;
    assign o_sat   = sat;

endmodule

// File: doc/alm_dot_accumulator.md
ALM_DOT_ACCUMULATOR -- requirements
Module: alm_dot_accumulator

Interface
REQ-001 Parameter ACC_WIDTH, default 40: accumulator and result width in bits (legal range 33..64).
REQ-002 Parameter MAX_LEN, default 256: maximum products per vector; a vector is force-closed on reaching it.
REQ-003 Port i_clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1: reset, asynchronous and active-high.
REQ-005 Port i_valid  input  1: product beat valid.
REQ-006 Port o_ready  output  1: block can accept a product beat this cycle.
REQ-007 Port i_prod  input  32 signed: product from the approximate log multiplier.
REQ-008 Port i_last  input  1: beat is the final product of the current vector.
REQ-009 Port i_clear  input  1: synchronous flush of the partial sum.
REQ-010 Port o_valid  output  1: result valid.
REQ-011 Port i_ready  input  1: downstream accepts the result.
REQ-012 Port o_acc  output  ACC_WIDTH signed: accumulated dot product.
REQ-013 Port o_count  output  $clog2(MAX_LEN+1): number of products in o_acc.
REQ-014 Port o_sat  output  1: saturation occurred at least once within this vector.

Function
REQ-015 Two states SHALL exist, ACCUM and HOLD; o_ready = 1 exactly in ACCUM, o_valid = 1 exactly in HOLD.
REQ-016 A beat SHALL be accepted iff i_valid && o_ready && !i_clear; on acceptance, acc <= sat(acc + sign-extended i_prod) and count <= count + 1.
REQ-017 Addition SHALL be performed at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; any clamp sets the sticky sat flag.
REQ-018 An accepted beat with i_last = 1, or one bringing count to MAX_LEN, SHALL move ACCUM->HOLD; o_valid rises the cycle after that beat (1-cycle latency).
REQ-019 In HOLD, o_acc, o_count and o_sat SHALL be stable; they change only on the cycle after i_ready is sampled high.
REQ-020 HOLD->ACCUM SHALL occur on i_ready = 1; the same edge clears acc, count and sat to 0.
REQ-021 No beat SHALL be accepted in the cycle that leaves HOLD (o_ready is still 0 that cycle); the first new beat is accepted the following cycle.
REQ-022 i_clear = 1 in ACCUM SHALL zero acc, count and sat and discard any beat presented that cycle; i_clear SHALL be ignored in HOLD.
REQ-023 i_last on a beat not accepted SHALL have no effect.
REQ-024 A vector closed by MAX_LEN without i_last SHALL still be emitted; subsequent beats start a new vector.
REQ-025 i_prod = 0 beats SHALL count toward o_count like any other beat.

Reset
REQ-026 On i_rst high: state = ACCUM, acc = 0, count = 0, sat = 0; hence o_ready = 1, o_valid = 0, o_acc = 0, o_count = 0, o_sat = 0.
REQ-027 Reset asserted in mid-vector or in HOLD SHALL discard all partial or pending results; no result is emitted afterward for that vector.

Structure
REQ-028 Package alm_acc_pkg SHALL hold the state enum (ACCUM, HOLD) and the default constants ACC_WIDTH_DEF = 40 and MAX_LEN_DEF = 256.
REQ-029 Saturating adder SHALL be one combinational sub-module, alm_sat_add (inputs: acc, sign-extended product; outputs: clamped sum, sat_hit).
REQ-030 Only acc, count, sat and the state register are registered; o_ready and o_valid are decoded from the state.

Verification
REQ-031 Beats 100, -30, 7 (last), i_ready = 1 -> o_valid the cycle after the last beat, o_acc = 77, o_count = 3, o_sat = 0.
REQ-032 ACC_WIDTH = 33, beats 0x7FFFFFFF x3 (last on 3rd) -> o_acc = 2^32-1, o_sat = 1; next vector 5 (last) -> o_acc = 5, o_sat = 0.
REQ-033 MAX_LEN = 4, six beats of 1, no i_last -> vector 1: o_acc = 4, o_count = 4; the remaining 2 beats are held as a partial sum.
REQ-034 HOLD with i_ready = 0 for 5 cycles, i_valid held high -> o_ready = 0 and outputs stable throughout; i_ready = 1 -> first new beat accepted 2 cycles later.
REQ-035 Beats 50, 60, then i_clear together with valid beat 9, then 4 (last) -> o_acc = 4, o_count = 1.
REQ-036 i_rst pulsed asynchronously mid-vector (after 2 beats) and again while in HOLD -> outputs are 0 immediately, o_ready = 1, and no stale result ever appears.
